// File: rtl/spm_sched_pkg.sv
// Shared types and sizing helpers for the serial-parallel multiplier scheduler.
package spm_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLR,
    SHIFT,
    DONE
  } state_t;

  localparam int unsigned DEF_W = 32;

  // Index of one of the two requesters.
  typedef logic req_idx_t;

  // Width of the shift counter, which counts 0 .. 2W-1+lat.
  function automatic int unsigned cnt_width(input int unsigned w, input int unsigned lat);
    return $clog2(2 * w + lat + 1);
  endfunction

endpackage

// File: rtl/spm_rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last granted requester.
module spm_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic [1:0] o_gnt
);

  // Last granted requester; reset value 1 so that requester 0 wins first.
  logic r_last;

  // One-hot grant: on contention serve the requester not granted last.
  always_comb begin
    o_gnt = '0;
    if (i_en) begin
      if (&i_req) o_gnt = r_last ? 2'b01 : 2'b10;
      else        o_gnt = i_req;
    end
  end

  // Pointer moves only when a grant is issued.
  always_ff @(posedge clk) begin
    if (rst)         r_last <= 1'b1;
    else if (|o_gnt) r_last <= o_gnt[1];
  end

endmodule

// File: rtl/spm_mul_sched.sv
// Scheduler sharing one external serial-parallel multiplier between two
// requesters. Optional performance counters: define SPM_SCHED_PERF_EN.
module spm_mul_sched
  import spm_sched_pkg::*;
#(
  parameter int unsigned W       = DEF_W,
  parameter int unsigned SPM_LAT = 1,
  parameter int unsigned SIGNED  = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [2*W-1:0] req_a,
  input  logic [2*W-1:0] req_x,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic           resp_id,
  output logic [2*W-1:0] resp_p,
  output logic           spm_rstn,
  output logic [W-1:0]   spm_a,
  output logic           spm_x,
  input  logic           spm_y
`ifdef SPM_SCHED_PERF_EN
  ,
  output logic [31:0]    perf_ops,
  output logic [31:0]    perf_busy
`endif
);

  localparam int unsigned CW = cnt_width(W, SPM_LAT);
  localparam logic [CW-1:0] C_LAT   = CW'(SPM_LAT);
  localparam logic [CW-1:0] C_LAST  = CW'(2 * W - 1 + SPM_LAT);
  localparam logic [CW-1:0] C_XLAST = CW'(2 * W - 1);

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_xsh;
  logic           r_ext;
  logic [2*W-1:0] r_p;
  logic           r_resp_valid;
  req_idx_t       r_resp_id;
  logic           r_spm_rstn;
  logic [W-1:0]   r_spm_a;
  logic           r_spm_x;

  logic [1:0]     w_gnt;
  logic           w_arb_en;
  logic [W-1:0]   w_a_sel;
  logic [W-1:0]   w_x_sel;

  assign w_arb_en = (r_state == IDLE) && !r_resp_valid && !rst;
  assign w_a_sel  = w_gnt[1] ? req_a[W +: W] : req_a[0 +: W];
  assign w_x_sel  = w_gnt[1] ? req_x[W +: W] : req_x[0 +: W];

  spm_rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .i_req (req_valid),
    .i_en  (w_arb_en),
    .o_gnt (w_gnt)
  );

  // Accept pulse is the grant itself, so requester data is sampled on that edge.
  assign req_ready  = w_gnt;
  assign resp_valid = r_resp_valid;
  assign resp_id    = r_resp_id;
  assign resp_p     = r_p;
  assign spm_rstn   = r_spm_rstn;
  assign spm_a      = r_spm_a;
  assign spm_x      = r_spm_x;

  // Operation FSM: grant, clear spm, stream x serially while collecting y, respond.
  // spm_x is registered one step ahead: the bit for count k+1 is loaded while
  // the counter holds k, so spm_x equals bit k throughout count k.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_xsh        <= '0;
      r_ext        <= 1'b0;
      r_p          <= '0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= 1'b0;
      r_spm_rstn   <= 1'b0;
      r_spm_a      <= '0;
      r_spm_x      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_spm_rstn <= 1'b1;
          if (|w_gnt) begin
            r_spm_a    <= w_a_sel;
            r_xsh      <= w_x_sel;
            r_ext      <= (SIGNED != 0) ? w_x_sel[W-1] : 1'b0;
            r_resp_id  <= w_gnt[1];
            r_spm_rstn <= 1'b0;
            r_spm_x    <= 1'b0;
            r_state    <= CLR;
          end
        end
        CLR: begin
          r_spm_rstn <= 1'b1;
          r_spm_x    <= r_xsh[0];
          r_xsh      <= {r_ext, r_xsh[W-1:1]};
          r_cnt      <= '0;
          r_state    <= SHIFT;
        end
        SHIFT: begin
          r_spm_x <= (r_cnt < C_XLAST) ? r_xsh[0] : 1'b0;
          r_xsh   <= {r_ext, r_xsh[W-1:1]};
          if (r_cnt >= C_LAT) r_p <= {spm_y, r_p[2*W-1:1]};
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == C_LAST) begin
            r_resp_valid <= 1'b1;
            r_state      <= DONE;
          end
        end
        DONE: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef SPM_SCHED_PERF_EN
  logic [31:0] r_perf_ops;
  logic [31:0] r_perf_busy;

  // Saturating counts of completed handshakes and non-idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_ops  <= '0;
      r_perf_busy <= '0;
    end else begin
      if ((r_state == DONE) && resp_ready && (r_perf_ops != '1))
        r_perf_ops <= r_perf_ops + 1'b1;
      if ((r_state != IDLE) && (r_perf_busy != '1))
        r_perf_busy <= r_perf_busy + 1'b1;
    end
  end

  assign perf_ops  = r_perf_ops;
  assign perf_busy = r_perf_busy;
`endif

endmodule

// File: tb/tb_spm_mul_sched.sv
// Self-checking bench for spm_mul_sched with a behavioural serial-parallel
// multiplier (W=32, SPM_LAT=1, SIGNED=1). Build with SPM_SCHED_PERF_EN to
// include the performance counter scenario.
module tb_spm_mul_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_x;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_id;
  logic [63:0] resp_p;
  logic        spm_rstn;
  logic [31:0] spm_a;
  logic        spm_x;
  logic        spm_y = 1'b0;
`ifdef SPM_SCHED_PERF_EN
  logic [31:0] perf_ops;
  logic [31:0] perf_busy;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        id;
    logic [63:0] p;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  spm_mul_sched #(.W(32), .SPM_LAT(1), .SIGNED(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_x      (req_x),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_p     (resp_p),
    .spm_rstn   (spm_rstn),
    .spm_a      (spm_a),
    .spm_x      (spm_x),
    .spm_y      (spm_y)
`ifdef SPM_SCHED_PERF_EN
    ,
    .perf_ops   (perf_ops),
    .perf_busy  (perf_busy)
`endif
  );

  // Behavioural spm: accumulates a_ext << i for each set x bit; y carries
  // product bit i one cycle after x bit i.
  logic [63:0] m_acc = '0;
  logic [6:0]  m_i   = '0;
  logic [63:0] m_t;
  always_comb m_t = m_acc + (spm_x ? ({{32{spm_a[31]}}, spm_a} << m_i) : 64'd0);
  always @(posedge clk) begin
    if (!spm_rstn) begin
      m_acc <= '0;
      m_i   <= '0;
      spm_y <= 1'b0;
    end else if (m_i < 7'd64) begin
      m_acc <= m_t;
      spm_y <= m_t[m_i[5:0]];
      m_i   <= m_i + 7'd1;
    end else begin
      spm_y <= 1'b0;
    end
  end

  function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] x);
    logic signed [63:0] sa;
    logic signed [63:0] sx;
    sa = $signed(a);
    sx = $signed(x);
    return sa * sx;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 2'b00;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic push_exp(input logic id);
    exp_t e;
    e.id = id;
    e.p  = id ? prod(req_a[63:32], req_x[63:32]) : prod(req_a[31:0], req_x[31:0]);
    exp_q.push_back(e);
  endtask

  task automatic pop_exp(output exp_t e, output bit ok);
    ok = (exp_q.size() != 0);
    e.id = 1'b0;
    e.p  = '0;
    if (ok) e = exp_q.pop_front();
  endtask

  // Raise req_valid, wait (bounded) for an accept, record the expectation and
  // step past the grant edge.
  task automatic grant_op(input logic [1:0] v, output logic [1:0] g, output bit ok);
    req_valid = v;
    #1;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (req_ready != 2'b00) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    g = req_ready;
    if (ok) push_exp(g[1]);
    tick();
  endtask

  task automatic wait_resp(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      tick();
      n++;
      if (resp_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 2'b11;
    resp_ready = 1'b1;
    req_a = {$urandom, $urandom};
    req_x = {$urandom, $urandom};
    repeat (3) tick();
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    checks++; if (resp_id !== 1'b0) begin failures++; $display("FAIL reset_resp_id: got %b expected 0", resp_id); end
    checks++; if (resp_p !== 64'd0) begin failures++; $display("FAIL reset_resp_p: got %h expected 0", resp_p); end
    checks++; if (spm_rstn !== 1'b0) begin failures++; $display("FAIL reset_spm_rstn: got %b expected 0", spm_rstn); end
    checks++; if (spm_a !== 32'd0) begin failures++; $display("FAIL reset_spm_a: got %h expected 0", spm_a); end
    checks++; if (spm_x !== 1'b0) begin failures++; $display("FAIL reset_spm_x: got %b expected 0", spm_x); end
    rst = 1'b0;
    req_valid = 2'b00;
    tick();
    checks++; if (spm_rstn !== 1'b1) begin failures++; $display("FAIL idle_spm_rstn: got %b expected 1", spm_rstn); end
  endtask

  task automatic test_basic();
    logic [1:0] g;
    bit ok;
    bit have;
    int n;
    exp_t e;
    req_a = {32'd0, 32'd3};
    req_x = {32'd0, 32'd5};
    grant_op(2'b01, g, ok);
    req_valid = 2'b00;
    checks++; if (!ok || g !== 2'b01) begin failures++; $display("FAIL basic_grant: got %b expected 01", g); end
    checks++; if (spm_rstn !== 1'b0 || spm_x !== 1'b0) begin failures++; $display("FAIL basic_clr: got rstn=%b x=%b expected rstn=0 x=0", spm_rstn, spm_x); end
    checks++; if (spm_a !== 32'd3) begin failures++; $display("FAIL basic_spm_a: got %h expected 3", spm_a); end
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL basic_ready_busy: got %b expected 00", req_ready); end
    wait_resp(n, ok);
    checks++; if (!ok || (n + 1) != 67) begin failures++; $display("FAIL basic_latency: got %0d (valid=%b) expected 67", n + 1, ok); end
    checks++; if (resp_p !== 64'd15 || resp_id !== 1'b0) begin failures++; $display("FAIL basic_result: got p=%h id=%b expected p=f id=0", resp_p, resp_id); end
    pop_exp(e, have);
    checks++; if (!have || resp_p !== e.p || resp_id !== e.id) begin failures++; $display("FAIL basic_sb: got p=%h id=%b expected p=%h id=%b", resp_p, resp_id, e.p, e.id); end
    tick();
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL basic_handshake: got valid=%b expected 0", resp_valid); end
  endtask

  task automatic test_signed();
    logic [31:0] ta [3];
    logic [31:0] tx [3];
    logic [63:0] tp [3];
    logic [1:0]  tv [3];
    logic [1:0]  g;
    bit ok;
    bit have;
    int n;
    exp_t e;
    ta[0] = 32'hFFFFFFF9; tx[0] = 32'd6;        tp[0] = 64'hFFFFFFFF_FFFFFFD6; tv[0] = 2'b01;
    ta[1] = 32'h80000000; tx[1] = 32'h80000000; tp[1] = 64'h40000000_00000000; tv[1] = 2'b10;
    ta[2] = 32'h7FFFFFFF; tx[2] = 32'hFFFFFFFF; tp[2] = 64'hFFFFFFFF_80000001; tv[2] = 2'b01;
    for (int i = 0; i < 3; i++) begin
      req_a = {ta[i], ta[i]};
      req_x = {tx[i], tx[i]};
      grant_op(tv[i], g, ok);
      req_valid = 2'b00;
      checks++; if (!ok || g !== tv[i]) begin failures++; $display("FAIL signed_grant[%0d]: got %b expected %b", i, g, tv[i]); end
      wait_resp(n, ok);
      checks++; if (!ok || resp_p !== tp[i]) begin failures++; $display("FAIL signed_p[%0d]: got %h expected %h", i, resp_p, tp[i]); end
      pop_exp(e, have);
      checks++; if (!have || resp_p !== e.p || resp_id !== e.id) begin failures++; $display("FAIL signed_sb[%0d]: got p=%h id=%b expected p=%h id=%b", i, resp_p, resp_id, e.p, e.id); end
      tick();
    end
  endtask

  task automatic test_rr();
    logic [1:0] order [4];
    logic [1:0] g;
    bit ok;
    bit have;
    int n;
    exp_t e;
    order[0] = 2'b01; order[1] = 2'b10; order[2] = 2'b01; order[3] = 2'b10;
    do_reset();
    req_a = {32'd1000, 32'd17};
    req_x = {32'hFFFFFFFE, 32'd23};
    for (int i = 0; i < 4; i++) begin
      grant_op(2'b11, g, ok);
      checks++; if (!ok || g !== order[i]) begin failures++; $display("FAIL rr_order[%0d]: got %b expected %b", i, g, order[i]); end
      if (g[1]) begin
        req_a[63:32] = $urandom;
        req_x[63:32] = $urandom;
      end else begin
        req_a[31:0] = $urandom;
        req_x[31:0] = $urandom;
      end
      wait_resp(n, ok);
      pop_exp(e, have);
      checks++; if (!ok || !have || resp_p !== e.p || resp_id !== e.id) begin failures++; $display("FAIL rr_result[%0d]: got p=%h id=%b expected p=%h id=%b", i, resp_p, resp_id, e.p, e.id); end
      tick();
    end
    req_valid = 2'b00;
  endtask

  task automatic test_stall();
    logic [1:0] g;
    bit ok;
    bit have;
    int n;
    exp_t e;
    resp_ready = 1'b0;
    req_a = {32'hFFFFFF00, 32'd0};
    req_x = {32'd300, 32'd0};
    grant_op(2'b10, g, ok);
    checks++; if (!ok || g !== 2'b10) begin failures++; $display("FAIL stall_grant: got %b expected 10", g); end
    req_a[31:0] = 32'd12345;
    req_x[31:0] = 32'hFFFF0000;
    req_valid = 2'b01;
    wait_resp(n, ok);
    pop_exp(e, have);
    checks++; if (!ok || !have || resp_p !== e.p || resp_id !== 1'b1) begin failures++; $display("FAIL stall_result: got p=%h id=%b expected p=%h id=1", resp_p, resp_id, e.p); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (resp_valid !== 1'b1 || resp_p !== e.p || resp_id !== 1'b1) begin failures++; $display("FAIL stall_hold[%0d]: got valid=%b p=%h id=%b expected valid=1 p=%h id=1", i, resp_valid, resp_p, resp_id, e.p); end
      checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL stall_no_grant[%0d]: got %b expected 00", i, req_ready); end
    end
    resp_ready = 1'b1;
    tick();
    checks++; if (resp_valid !== 1'b0 || req_ready !== 2'b01) begin failures++; $display("FAIL stall_release: got valid=%b ready=%b expected valid=0 ready=01", resp_valid, req_ready); end
    push_exp(1'b0);
    tick();
    req_valid = 2'b00;
    wait_resp(n, ok);
    pop_exp(e, have);
    checks++; if (!ok || !have || resp_p !== e.p || resp_id !== 1'b0) begin failures++; $display("FAIL stall_next: got p=%h id=%b expected p=%h id=0", resp_p, resp_id, e.p); end
    tick();
  endtask

  task automatic test_rst_mid();
    logic [1:0] g;
    logic [31:0] xv;
    bit ok;
    bit have;
    bit seen;
    int n;
    exp_t e;
    xv = 32'hFFFFFFFD;
    req_a = {32'd0, 32'd1234};
    req_x = {32'd0, xv};
    grant_op(2'b01, g, ok);
    req_valid = 2'b00;
    repeat (21) tick();
    checks++; if (!ok || spm_x !== xv[20] || spm_a !== 32'd1234) begin failures++; $display("FAIL rstmid_k20: got x=%b a=%h expected x=%b a=4d2", spm_x, spm_a, xv[20]); end
    rst = 1'b1;
    tick();
    checks++; if (resp_valid !== 1'b0 || resp_p !== 64'd0 || resp_id !== 1'b0) begin failures++; $display("FAIL rstmid_resp: got valid=%b p=%h id=%b expected 0", resp_valid, resp_p, resp_id); end
    checks++; if (spm_rstn !== 1'b0 || spm_a !== 32'd0 || spm_x !== 1'b0 || req_ready !== 2'b00) begin failures++; $display("FAIL rstmid_spm: got rstn=%b a=%h x=%b ready=%b expected all 0", spm_rstn, spm_a, spm_x, req_ready); end
    rst = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (resp_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rstmid_no_resp: got response=%b expected 0", seen); end
    req_a = {32'hFFFFFF9C, 32'd0};
    req_x = {32'd77, 32'd0};
    grant_op(2'b10, g, ok);
    req_valid = 2'b00;
    wait_resp(n, ok);
    pop_exp(e, have);
    checks++; if (!ok || !have || resp_p !== 64'hFFFFFFFF_FFFFE1EC || resp_id !== 1'b1) begin failures++; $display("FAIL rstmid_next: got p=%h id=%b expected p=ffffffffffffe1ec id=1", resp_p, resp_id); end
    tick();
  endtask

`ifdef SPM_SCHED_PERF_EN
  task automatic test_perf();
    logic [1:0] g;
    bit ok;
    bit have;
    int n;
    exp_t e;
    resp_ready = 1'b1;
    do_reset();
    checks++; if (perf_ops !== 32'd0 || perf_busy !== 32'd0) begin failures++; $display("FAIL perf_reset: got ops=%0d busy=%0d expected 0 0", perf_ops, perf_busy); end
    for (int i = 0; i < 3; i++) begin
      req_a = {$urandom, $urandom};
      req_x = {$urandom, $urandom};
      grant_op(2'b11, g, ok);
      req_valid = 2'b00;
      wait_resp(n, ok);
      pop_exp(e, have);
      checks++; if (!ok || !have || resp_p !== e.p || resp_id !== e.id) begin failures++; $display("FAIL perf_result[%0d]: got p=%h expected %h", i, resp_p, e.p); end
      tick();
    end
    tick();
    checks++; if (perf_ops !== 32'd3) begin failures++; $display("FAIL perf_ops: got %0d expected 3", perf_ops); end
    checks++; if (perf_busy !== 32'd201) begin failures++; $display("FAIL perf_busy: got %0d expected 201", perf_busy); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    req_valid = 2'b00;
    resp_ready = 1'b1;
    req_a = '0;
    req_x = '0;
    test_reset();
    test_basic();
    test_signed();
    test_rr();
    test_stall();
    test_rst_mid();
`ifdef SPM_SCHED_PERF_EN
    test_perf();
`endif
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL sb_drain: got %0d pending expected 0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
